// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I controller, datapath muxes and ALU decoder.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADR   = 4'd2;
    localparam logic [3:0] S_MEM_READ  = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WRITE = 4'd5;
    localparam logic [3:0] S_EXEC_R    = 4'd6;
    localparam logic [3:0] S_EXEC_I    = 4'd7;
    localparam logic [3:0] S_ALU_WB    = 4'd8;
    localparam logic [3:0] S_BRANCH    = 4'd9;
    localparam logic [3:0] S_JAL       = 4'd10;

    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLD_PC = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = 2'b10;

    localparam logic [1:0] ALU_ADD     = 2'b00;
    localparam logic [1:0] ALU_SUB     = 2'b01;
    localparam logic [1:0] ALU_FUNCT   = 2'b10;

    localparam logic [2:0] IMM_I       = 3'b000;
    localparam logic [2:0] IMM_S       = 3'b001;
    localparam logic [2:0] IMM_B       = 3'b010;
    localparam logic [2:0] IMM_J       = 3'b011;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEM     = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_STORE:  imm_sel = IMM_S;
            OP_BRANCH: imm_sel = IMM_B;
            OP_JAL:    imm_sel = IMM_J;
            default:   imm_sel = IMM_I;
        endcase
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL: is_legal = 1'b1;
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outputs.sv
// Combinational control word for each sequencer state; everything is held at 0 while
// active is low so no enable can rise during reset.
module mc_ctrl_outputs
    import ctrl_pkg::*;
(
    input  logic       active,
    input  logic [3:0] state,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic [1:0] result_src,
    output logic       illegal_instr,
    output logic       instr_retired
);

    logic pc_update;
    logic branch;

    always_comb begin
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        alu_op        = ALU_ADD;
        imm_src       = IMM_I;
        result_src    = RES_ALUOUT;
        illegal_instr = 1'b0;
        instr_retired = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        if (active) begin
            imm_src = imm_sel(opcode);
            case (state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    ir_write   = mem_ready;
                    pc_update  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a     = SRCA_OLD_PC;
                    alu_src_b     = SRCB_IMM;
                    illegal_instr = !is_legal(opcode);
                end
                S_MEM_ADR: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_READ: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEM_WB: begin
                    result_src    = RES_MEM;
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_MEM_WRITE: begin
                    mem_req       = 1'b1;
                    mem_write     = 1'b1;
                    adr_src       = 1'b1;
                    instr_retired = mem_ready;
                end
                S_EXEC_R: begin
                    alu_src_a = SRCA_RS1;
                    alu_op    = ALU_FUNCT;
                end
                S_EXEC_I: begin
                    alu_src_a = SRCA_RS1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = SRCA_RS1;
                    alu_op        = ALU_SUB;
                    branch        = 1'b1;
                    instr_retired = 1'b1;
                end
                S_JAL: begin
                    alu_src_a = SRCA_OLD_PC;
                    alu_src_b = SRCB_FOUR;
                    pc_update = 1'b1;
                end
                default: ;
            endcase
            pc_write = pc_update | (branch & zero);
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: state register, next-state decode and retired-instruction counter.
// Memory handshake: a request (mem_req with mem_write/adr_src) is held unchanged until the cycle mem_ready is high.
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int RETIRE_CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              opcode,
    input  logic                    zero,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_write,
    output logic                    adr_src,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic                    reg_write,
    output logic [1:0]              alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              alu_op,
    output logic [2:0]              imm_src,
    output logic [1:0]              result_src,
    output logic                    illegal_instr,
    output logic                    instr_retired,
    output logic [RETIRE_CNT_W-1:0] retire_count
);

    logic [3:0] state;
    logic [3:0] state_next;

    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_FETCH:     state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEM_ADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_I:              state_next = S_EXEC_I;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    default:           state_next = S_FETCH;
                endcase
            end
            S_MEM_ADR:   state_next = (opcode == OP_STORE) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXEC_R,
            S_EXEC_I,
            S_JAL:       state_next = S_ALU_WB;
            default:     state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             retire_count <= '0;
        else if (instr_retired) retire_count <= retire_count + 1'b1;
    end

    mc_ctrl_outputs u_outputs (
        .active        (rst_n),
        .state         (state),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .zero          (zero),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_src       (imm_src),
        .result_src    (result_src),
        .illegal_instr (illegal_instr),
        .instr_retired (instr_retired)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: per-cycle control-word traces per instruction class,
// with a queue of expected retire counts popped after each retiring edge.
module tb_multicycle_ctrl_fsm;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [2:0] imm_src;
    logic       illegal_instr, instr_retired;
    logic [3:0] retire_count;

    logic [18:0] ctl;
    assign ctl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, alu_op, imm_src, result_src,
                  illegal_instr, instr_retired};

    int         checks;
    int         errors;
    logic [3:0] model_cnt;
    logic [3:0] exp_q[$];
    logic [3:0] got;

    multicycle_ctrl_fsm #(.RETIRE_CNT_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .adr_src       (adr_src),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .imm_src       (imm_src),
        .result_src    (result_src),
        .illegal_instr (illegal_instr),
        .instr_retired (instr_retired),
        .retire_count  (retire_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] mk(input logic mreq, input logic mwr, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] op, input logic [2:0] imm,
                                       input logic [1:0] rs, input logic ill, input logic ret);
        mk = {mreq, mwr, adr, irw, pcw, rw, a, b, op, imm, rs, ill, ret};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mr code: 0/1 drive mem_ready, 2 = random (cycle without a request)
    task automatic drive_cycle(input int mr);
        mem_ready = (mr == 2) ? 1'($urandom_range(0, 1)) : 1'(mr);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; opcode = 7'b0110011; mem_ready = 1'b1; zero = 1'b1;
        #3;
        checks++;
        if (ctl !== 19'd0) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 19'd0); end
        checks++;
        if (retire_count !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", retire_count); end
        tick(); tick();
        rst_n = 1'b1; mem_ready = 1'b0;
        #2;
        checks++;
        if (ctl !== mk(1,0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,2'd2,0,0))
            begin errors++; $display("FAIL reset_first_fetch got=%b", ctl); end
        tick();
    endtask

    task automatic test_add();
        logic [18:0] ew [4];
        ew[0] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd0,2'd2,0,0);
        ew[1] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd0,2'd0,0,0);
        ew[2] = mk(0,0,0,0,0,0,2'd2,2'd0,2'd2,3'd0,2'd0,0,0);
        ew[3] = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd0,0,1);
        opcode = 7'b0110011;
        for (int i = 0; i < 4; i++) begin
            drive_cycle((i == 0) ? 1 : 2);
            zero = 1'($urandom_range(0, 1));
            #2;
            checks++;
            if (ctl !== ew[i]) begin errors++; $display("FAIL add cyc%0d got=%b exp=%b", i, ctl, ew[i]); end
            if (ew[i][0]) begin model_cnt = model_cnt + 1'b1; exp_q.push_back(model_cnt); end
            tick();
            if (ew[i][0]) begin
                got = exp_q.pop_front(); checks++;
                if (retire_count !== got) begin errors++; $display("FAIL add_cnt got=%0d exp=%0d", retire_count, got); end
            end
        end
    endtask

    task automatic test_load();
        logic [18:0] ew [8];
        int          mr [8];
        mr = '{1, 0, 0, 0, 0, 0, 1, 2};
        ew[0] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd0,2'd2,0,0);
        ew[1] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd0,2'd0,0,0);
        ew[2] = mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,3'd0,2'd0,0,0);
        for (int i = 3; i < 7; i++) ew[i] = mk(1,0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,2'd0,0,0);
        ew[7] = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd1,0,1);
        opcode = 7'b0000011;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(mr[i]);
            zero = 1'($urandom_range(0, 1));
            #2;
            checks++;
            if (ctl !== ew[i]) begin errors++; $display("FAIL load cyc%0d got=%b exp=%b", i, ctl, ew[i]); end
            if (ew[i][0]) begin model_cnt = model_cnt + 1'b1; exp_q.push_back(model_cnt); end
            tick();
            if (ew[i][0]) begin
                got = exp_q.pop_front(); checks++;
                if (retire_count !== got) begin errors++; $display("FAIL load_cnt got=%0d exp=%0d", retire_count, got); end
            end
        end
    endtask

    task automatic test_store();
        logic [18:0] ew [6];
        int          mr [6];
        mr = '{0, 1, 2, 2, 0, 1};
        ew[0] = mk(1,0,0,0,0,0,2'd0,2'd2,2'd0,3'd1,2'd2,0,0);
        ew[1] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd1,2'd2,0,0);
        ew[2] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd1,2'd0,0,0);
        ew[3] = mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,3'd1,2'd0,0,0);
        ew[4] = mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,3'd1,2'd0,0,0);
        ew[5] = mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,3'd1,2'd0,0,1);
        opcode = 7'b0100011;
        for (int i = 0; i < 6; i++) begin
            drive_cycle(mr[i]);
            zero = 1'($urandom_range(0, 1));
            #2;
            checks++;
            if (ctl !== ew[i]) begin errors++; $display("FAIL store cyc%0d got=%b exp=%b", i, ctl, ew[i]); end
            if (ew[i][0]) begin model_cnt = model_cnt + 1'b1; exp_q.push_back(model_cnt); end
            tick();
            if (ew[i][0]) begin
                got = exp_q.pop_front(); checks++;
                if (retire_count !== got) begin errors++; $display("FAIL store_cnt got=%0d exp=%0d", retire_count, got); end
            end
        end
    endtask

    task automatic test_branch(input logic z);
        logic [18:0] ew [3];
        ew[0] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd2,2'd2,0,0);
        ew[1] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd2,2'd0,0,0);
        ew[2] = mk(0,0,0,0,z,0,2'd2,2'd0,2'd1,3'd2,2'd0,0,1);
        opcode = 7'b1100011;
        zero = z;
        for (int i = 0; i < 3; i++) begin
            drive_cycle((i == 0) ? 1 : 2);
            #2;
            checks++;
            if (ctl !== ew[i]) begin errors++; $display("FAIL beq_z%0d cyc%0d got=%b exp=%b", z, i, ctl, ew[i]); end
            if (ew[i][0]) begin model_cnt = model_cnt + 1'b1; exp_q.push_back(model_cnt); end
            tick();
            if (ew[i][0]) begin
                got = exp_q.pop_front(); checks++;
                if (retire_count !== got) begin errors++; $display("FAIL beq_cnt got=%0d exp=%0d", retire_count, got); end
            end
        end
    endtask

    task automatic test_illegal();
        logic [18:0] ew [3];
        ew[0] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd0,2'd2,0,0);
        ew[1] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd0,2'd0,1,0);
        ew[2] = mk(1,0,0,0,0,0,2'd0,2'd2,2'd0,3'd0,2'd2,0,0);
        opcode = 7'b1111111;
        for (int i = 0; i < 3; i++) begin
            drive_cycle((i == 1) ? 2 : ((i == 0) ? 1 : 0));
            zero = 1'($urandom_range(0, 1));
            #2;
            checks++;
            if (ctl !== ew[i]) begin errors++; $display("FAIL illegal cyc%0d got=%b exp=%b", i, ctl, ew[i]); end
            tick();
        end
        checks++;
        if (retire_count !== model_cnt) begin errors++; $display("FAIL illegal_cnt got=%0d exp=%0d", retire_count, model_cnt); end
    endtask

    task automatic test_reset_mid_store();
        logic [18:0] ew [5];
        int          mr [5];
        mr = '{1, 2, 2, 0, 0};
        ew[0] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd1,2'd2,0,0);
        ew[1] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd1,2'd0,0,0);
        ew[2] = mk(0,0,0,0,0,0,2'd2,2'd1,2'd0,3'd1,2'd0,0,0);
        ew[3] = mk(1,1,1,0,0,0,2'd0,2'd0,2'd0,3'd1,2'd0,0,0);
        ew[4] = ew[3];
        opcode = 7'b0100011;
        for (int i = 0; i < 5; i++) begin
            drive_cycle(mr[i]);
            #2;
            checks++;
            if (ctl !== ew[i]) begin errors++; $display("FAIL mid_store cyc%0d got=%b exp=%b", i, ctl, ew[i]); end
            tick();
        end
        mem_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        model_cnt = 4'd0;
        exp_q.delete();
        checks++;
        if (ctl !== 19'd0) begin errors++; $display("FAIL mid_rst_ctl got=%b exp=0", ctl); end
        checks++;
        if (retire_count !== 4'd0) begin errors++; $display("FAIL mid_rst_cnt got=%0d exp=0", retire_count); end
        mem_ready = 1'b1;
        tick();
        checks++;
        if (ctl !== 19'd0) begin errors++; $display("FAIL mid_rst_hold got=%b exp=0", ctl); end
        rst_n = 1'b1; mem_ready = 1'b0;
        #2;
        checks++;
        if (ctl !== mk(1,0,0,0,0,0,2'd0,2'd2,2'd0,3'd1,2'd2,0,0))
            begin errors++; $display("FAIL mid_rst_fetch got=%b", ctl); end
        tick();
    endtask

    task automatic test_back_to_back_wrap();
        logic [18:0] ew [4];
        ew[0] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd0,2'd2,0,0);
        ew[1] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd0,2'd0,0,0);
        ew[2] = mk(0,0,0,0,0,0,2'd2,2'd1,2'd2,3'd0,2'd0,0,0);
        ew[3] = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,2'd0,0,1);
        opcode = 7'b0010011;
        for (int n = 0; n < 17; n++) begin
            for (int i = 0; i < 4; i++) begin
                drive_cycle((i == 0) ? 1 : 2);
                zero = 1'($urandom_range(0, 1));
                #2;
                checks++;
                if (ctl !== ew[i]) begin errors++; $display("FAIL addi%0d cyc%0d got=%b exp=%b", n, i, ctl, ew[i]); end
                if (ew[i][0]) begin model_cnt = model_cnt + 1'b1; exp_q.push_back(model_cnt); end
                tick();
                if (ew[i][0]) begin
                    got = exp_q.pop_front(); checks++;
                    if (retire_count !== got) begin errors++; $display("FAIL addi_cnt got=%0d exp=%0d", retire_count, got); end
                end
            end
        end
        checks++;
        if (retire_count !== 4'd1) begin errors++; $display("FAIL wrap_cnt got=%0d exp=1", retire_count); end
    endtask

    task automatic test_jal();
        logic [18:0] ew [4];
        ew[0] = mk(1,0,0,1,1,0,2'd0,2'd2,2'd0,3'd3,2'd2,0,0);
        ew[1] = mk(0,0,0,0,0,0,2'd1,2'd1,2'd0,3'd3,2'd0,0,0);
        ew[2] = mk(0,0,0,0,1,0,2'd1,2'd2,2'd0,3'd3,2'd0,0,0);
        ew[3] = mk(0,0,0,0,0,1,2'd0,2'd0,2'd0,3'd3,2'd0,0,1);
        opcode = 7'b1101111;
        for (int i = 0; i < 4; i++) begin
            drive_cycle((i == 0) ? 1 : 2);
            zero = 1'($urandom_range(0, 1));
            #2;
            checks++;
            if (ctl !== ew[i]) begin errors++; $display("FAIL jal cyc%0d got=%b exp=%b", i, ctl, ew[i]); end
            if (ew[i][0]) begin model_cnt = model_cnt + 1'b1; exp_q.push_back(model_cnt); end
            tick();
            if (ew[i][0]) begin
                got = exp_q.pop_front(); checks++;
                if (retire_count !== got) begin errors++; $display("FAIL jal_cnt got=%0d exp=%0d", retire_count, got); end
            end
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 4'd0;
        test_reset();
        test_add();
        test_load();
        test_store();
        test_branch(1'b1);
        test_branch(1'b0);
        test_illegal();
        test_reset_mid_store();
        test_back_to_back_wrap();
        test_jal();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
